// File: rtl/iir_pkg.sv
// Shared definitions for the biquad IIR filter chain: Q-format widths, DSP48A1
// opmode encodings, sequencer state and coefficient addresses.
package iir_pkg;

    // Q-format widths
    localparam int unsigned DATA_W    = 18;  // Q1.17 samples
    localparam int unsigned COEF_W    = 18;  // Q2.16 coefficients
    localparam int unsigned ACC_W     = 48;  // DSP P register
    localparam int unsigned PROD_FRAC = 33;  // product is Q3.33

    localparam int unsigned NUM_TAPS    = 5;
    localparam int unsigned TAP_W       = 3;
    localparam int unsigned COEF_ADDR_W = 3;

    // DSP X/Z mux encodings
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b10;

    // Coefficient addresses; also the tap index that consumes each coefficient
    localparam logic [COEF_ADDR_W-1:0] COEF_B0 = 3'd0;
    localparam logic [COEF_ADDR_W-1:0] COEF_B1 = 3'd1;
    localparam logic [COEF_ADDR_W-1:0] COEF_B2 = 3'd2;
    localparam logic [COEF_ADDR_W-1:0] COEF_A1 = 3'd3;
    localparam logic [COEF_ADDR_W-1:0] COEF_A2 = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWait,
        StOut
    } state_e;

    typedef struct packed {
        logic [1:0] x_in;
        logic [1:0] z_in;
        logic       use_preadd;
        logic       cryin;
        logic       preadd_sub;
        logic       postadd_sub;
    } opmode_t;

    // X=0, Z=P: the P register keeps its value
    localparam opmode_t OPMODE_HOLD = {X_ZERO, Z_P, 4'b0000};

    // Tap 0 loads P with the product, taps 1-2 add, the feedback taps 3-4 subtract.
    function automatic opmode_t opmode_for_tap(input logic [TAP_W-1:0] tap);
        opmode_t op;
        op             = '0;
        op.x_in        = X_M;
        op.z_in        = (tap == COEF_B0) ? Z_ZERO : Z_P;
        op.postadd_sub = (tap >= COEF_A1);
        return op;
    endfunction

endpackage

// File: rtl/iir_sat_trunc.sv
// Combinational 48-bit Q3.33 accumulator to 18-bit Q1.17 sample: saturate when the
// integer bits do not fit, otherwise drop the low fraction bits.
module iir_sat_trunc
    import iir_pkg::*;
(
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] y_o
);

    localparam int unsigned TOP_W = ACC_W - PROD_FRAC;
    localparam int unsigned LSB   = PROD_FRAC - DATA_W + 1;

    logic [TOP_W-1:0] top_bits;
    logic             fits;

    assign top_bits = acc_i[ACC_W-1:PROD_FRAC];

    // Value fits when every bit from the sign down to bit PROD_FRAC agrees
    always_comb begin
        fits = (top_bits == {TOP_W{acc_i[ACC_W-1]}});
        if (fits) begin
            y_o = acc_i[PROD_FRAC:LSB];
        end else if (acc_i[ACC_W-1]) begin
            y_o = {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            y_o = {1'b0, {(DATA_W - 1){1'b1}}};
        end
    end

endmodule

// File: rtl/iir_biquad_seq.sv
// Direct-form-I biquad sequencer: per accepted sample it issues five MAC taps to an
// external DSP48A1, waits P_LAT cycles for the pipeline, then saturates the sum into
// the output sample and shifts the x/y history.
module iir_biquad_seq
    import iir_pkg::*;
#(
    parameter int unsigned OP_DLY = 1,
    parameter int unsigned P_LAT  = 3
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [DATA_W-1:0]      sample_in,
    input  logic                   sample_in_valid,
    output logic                   sample_in_ready,

    output logic [DATA_W-1:0]      sample_out,
    output logic                   sample_out_valid,

    input  logic                   coef_wr,
    input  logic [COEF_ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0]      coef_data,

    output logic [1:0]             opmode_x_in,
    output logic [1:0]             opmode_z_in,
    output logic                   opmode_use_preadd,
    output logic                   opmode_cryin,
    output logic                   opmode_preadd_sub,
    output logic                   opmode_postadd_sub,

    output logic [DATA_W-1:0]      ain,
    output logic [COEF_W-1:0]      bin,
    input  logic [ACC_W-1:0]       pout
);

    localparam int unsigned WAIT_W = (P_LAT > 1) ? $clog2(P_LAT) : 1;
    localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(P_LAT - 1);

    state_e              state_q, state_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                ready_q, ready_d;
    logic                accept;
    logic                out_en;

    opmode_t             op_cur;
    opmode_t             op_dly_q [OP_DLY];

    logic [COEF_W-1:0]   stage_q [NUM_TAPS];
    logic [COEF_W-1:0]   act_q   [NUM_TAPS];
    logic [DATA_W-1:0]   x0_q, x1_q, x2_q, y1_q, y2_q;

    logic [DATA_W-1:0]   tap_data;
    logic [COEF_W-1:0]   tap_coef;
    logic [DATA_W-1:0]   y_sat;
    logic [DATA_W-1:0]   sample_out_q;
    logic                sample_out_valid_q;

    // Sequencer state, tap/wait counters and registered ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tap_q   <= '0;
            wait_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            wait_q  <= wait_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: IDLE -> MAC x5 -> WAIT x P_LAT -> OUT -> IDLE
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        out_en  = 1'b0;
        op_cur  = OPMODE_HOLD;
        unique case (state_q)
            StIdle: begin
                if (sample_in_valid && ready_q) begin
                    accept  = 1'b1;
                    tap_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                op_cur = opmode_for_tap(tap_q);
                if (tap_q == LAST_TAP) begin
                    wait_d  = '0;
                    state_d = StWait;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            StWait: begin
                if (wait_q == LAST_WAIT) begin
                    state_d = StOut;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StOut: begin
                out_en  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Ready rises only after a full IDLE cycle, so the output cycle is not
        // also an acceptance cycle.
        ready_d = (state_d == StIdle) && (state_q == StIdle);
    end

    // Tap operand select: data and coefficient for the current tap, zero outside MAC
    always_comb begin
        tap_data = '0;
        tap_coef = '0;
        if (state_q == StMac) begin
            case (tap_q)
                COEF_B0: begin tap_data = x0_q; tap_coef = act_q[0]; end
                COEF_B1: begin tap_data = x1_q; tap_coef = act_q[1]; end
                COEF_B2: begin tap_data = x2_q; tap_coef = act_q[2]; end
                COEF_A1: begin tap_data = y1_q; tap_coef = act_q[3]; end
                COEF_A2: begin tap_data = y2_q; tap_coef = act_q[4]; end
                default: begin tap_data = '0;   tap_coef = '0;       end
            endcase
        end
    end

    // Staging coefficients accept writes at any time; addresses past a2 are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (coef_wr && (coef_addr == COEF_ADDR_W'(i))) begin
                    stage_q[i] <= coef_data;
                end
            end
        end
    end

    // Acceptance latches the sample and snapshots staging into the active set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                act_q[i] <= '0;
            end
        end else if (accept) begin
            x0_q  <= sample_in;
            act_q <= stage_q;
        end
    end

    iir_sat_trunc u_sat (
        .acc_i (pout),
        .y_o   (y_sat)
    );

    // Output register and history shift on the OUT cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out_q       <= '0;
            sample_out_valid_q <= 1'b0;
            x1_q               <= '0;
            x2_q               <= '0;
            y1_q               <= '0;
            y2_q               <= '0;
        end else begin
            sample_out_valid_q <= out_en;
            if (out_en) begin
                sample_out_q <= y_sat;
                x2_q         <= x1_q;
                x1_q         <= x0_q;
                y2_q         <= y1_q;
                y1_q         <= y_sat;
            end
        end
    end

    // Opmode delay line: aligns each tap's opmode with its product at the post-adder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OP_DLY; i++) begin
                op_dly_q[i] <= '0;
            end
        end else begin
            op_dly_q[0] <= op_cur;
            for (int i = 1; i < OP_DLY; i++) begin
                op_dly_q[i] <= op_dly_q[i-1];
            end
        end
    end

    assign opmode_x_in        = op_dly_q[OP_DLY-1].x_in;
    assign opmode_z_in        = op_dly_q[OP_DLY-1].z_in;
    assign opmode_use_preadd  = op_dly_q[OP_DLY-1].use_preadd;
    assign opmode_cryin       = op_dly_q[OP_DLY-1].cryin;
    assign opmode_preadd_sub  = op_dly_q[OP_DLY-1].preadd_sub;
    assign opmode_postadd_sub = op_dly_q[OP_DLY-1].postadd_sub;

    assign ain              = tap_data;
    assign bin              = tap_coef;
    assign sample_in_ready  = ready_q;
    assign sample_out       = sample_out_q;
    assign sample_out_valid = sample_out_valid_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq: a DSP48A1 stub closes the loop on pout, a per-cycle
// model predicts handshake, tap operands, opmode and filtered output, and directed
// tests pin the model with hand-computed values.
module tb_iir_biquad_seq;

    localparam int OP_DLY = 1;
    localparam int P_LAT  = 3;
    localparam int LAT    = P_LAT + 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] sample_in = '0;
    logic        sample_in_valid = 1'b0;
    logic        sample_in_ready;
    logic [17:0] sample_out;
    logic        sample_out_valid;
    logic        coef_wr = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [17:0] coef_data = '0;
    logic [1:0]  opmode_x_in, opmode_z_in;
    logic        opmode_use_preadd, opmode_cryin, opmode_preadd_sub, opmode_postadd_sub;
    logic [17:0] ain, bin;
    logic [47:0] pout;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    iir_biquad_seq #(
        .OP_DLY (OP_DLY),
        .P_LAT  (P_LAT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .sample_in          (sample_in),
        .sample_in_valid    (sample_in_valid),
        .sample_in_ready    (sample_in_ready),
        .sample_out         (sample_out),
        .sample_out_valid   (sample_out_valid),
        .coef_wr            (coef_wr),
        .coef_addr          (coef_addr),
        .coef_data          (coef_data),
        .opmode_x_in        (opmode_x_in),
        .opmode_z_in        (opmode_z_in),
        .opmode_use_preadd  (opmode_use_preadd),
        .opmode_cryin       (opmode_cryin),
        .opmode_preadd_sub  (opmode_preadd_sub),
        .opmode_postadd_sub (opmode_postadd_sub),
        .ain                (ain),
        .bin                (bin),
        .pout               (pout)
    );

    // DSP48A1 stub: M register, then P = Z +/- X with the delayed opmode
    logic signed [35:0] m_q;
    logic signed [47:0] p_q, dsp_x, dsp_z, dsp_p;
    always_comb begin
        dsp_x = (opmode_x_in == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'sd0;
        dsp_z = (opmode_z_in == 2'b10) ? p_q : 48'sd0;
        dsp_p = opmode_postadd_sub ? (dsp_z - dsp_x) : (dsp_z + dsp_x);
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0;
            p_q <= '0;
        end else begin
            m_q <= $signed(ain) * $signed(bin);
            p_q <= dsp_p;
        end
    end
    assign pout = p_q;

    logic [7:0] opm;
    assign opm = {opmode_x_in, opmode_z_in, opmode_use_preadd, opmode_cryin,
                  opmode_preadd_sub, opmode_postadd_sub};

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // y = b0 x0 + b1 x1 + b2 x2 - a1 y1 - a2 y2 in Q3.33, clamped to Q1.17
    function automatic logic [17:0] to_sample(input longint acc);
        longint sh;
        if (acc >= (longint'(1) <<< 33)) return 18'h1FFFF;
        if (acc < -(longint'(1) <<< 33)) return 18'h20000;
        sh = acc >>> 16;
        return sh[17:0];
    endfunction

    // Opmode the DSP must see for tap k: load, add, add, subtract, subtract
    function automatic logic [7:0] tap_opmode(input int k);
        logic [1:0] z;
        z = (k == 0) ? 2'b00 : 2'b10;
        return {2'b01, z, 3'b000, (k >= 3)};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic signed [17:0] stg [5];
    logic signed [17:0] tap_a [5];
    logic signed [17:0] tap_b [5];
    logic signed [17:0] mx1, mx2, my1, my2;
    logic [17:0] exp_y, ea, eb;
    logic [7:0]  eo;
    longint      acc;
    int          cyc, acc_cyc, since_rst, d, k;
    bit          have_acc, er, ev;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < 5; i++) stg[i] = '0;
                mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
                have_acc = 1'b0; cyc = 0; acc_cyc = 0; since_rst = 0;
                chk(sample_in_ready == 1'b1, "rst ready", sample_in_ready, 1);
                chk(sample_out_valid == 1'b0, "rst out_valid", sample_out_valid, 0);
                chk(sample_out == 18'h0, "rst sample_out", sample_out, 0);
                chk(ain == 18'h0 && bin == 18'h0, "rst ain/bin", {ain, bin}, 0);
                chk(opm == 8'h00, "rst opmode", opm, 0);
            end else begin
                er = !(have_acc && cyc <= acc_cyc + LAT);
                ev = have_acc && (cyc == acc_cyc + LAT);
                chk(sample_in_ready == er, "ready", sample_in_ready, er);
                chk(sample_out_valid == ev, "out_valid", sample_out_valid, ev);
                if (ev) chk(sample_out == exp_y, "sample_out", sample_out, exp_y);
                d = cyc - acc_cyc - 1;
                ea = '0; eb = '0;
                if (have_acc && d >= 0 && d < 5) begin
                    ea = tap_a[d];
                    eb = tap_b[d];
                end
                chk(ain == ea, "ain", ain, ea);
                chk(bin == eb, "bin", bin, eb);
                k = d - OP_DLY;
                if (since_rst < OP_DLY) eo = 8'h00;
                else if (have_acc && k >= 0 && k < 5) eo = tap_opmode(k);
                else eo = 8'h20;
                chk(opm == eo, "opmode", opm, eo);
                if (er && sample_in_valid) begin
                    tap_a[0] = sample_in; tap_a[1] = mx1; tap_a[2] = mx2;
                    tap_a[3] = my1;       tap_a[4] = my2;
                    for (int i = 0; i < 5; i++) tap_b[i] = stg[i];
                    acc = 0;
                    for (int i = 0; i < 5; i++) begin
                        if (i < 3) acc += longint'(tap_a[i]) * longint'(tap_b[i]);
                        else       acc -= longint'(tap_a[i]) * longint'(tap_b[i]);
                    end
                    exp_y = to_sample(acc);
                    mx2 = mx1; mx1 = tap_a[0];
                    my2 = my1; my1 = exp_y;
                    acc_cyc = cyc; have_acc = 1'b1;
                end
                if (coef_wr && coef_addr < 3'd5) stg[int'(coef_addr)] = coef_data;
                cyc++;
                since_rst++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [17:0] v);
        @(posedge clk); #1;
        coef_wr = 1'b1; coef_addr = a; coef_data = v;
        @(posedge clk); #1;
        coef_wr = 1'b0;
    endtask

    task automatic send(input logic [17:0] x);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!sample_in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(sample_in_ready, "ready before send", sample_in_ready, 1);
        sample_in = x; sample_in_valid = 1'b1;
        @(posedge clk); #1;
        sample_in_valid = 1'b0;
    endtask

    // Waits for the next output pulse; lat>0 also pins the acceptance-to-valid delay
    task automatic expect_out(input logic [17:0] e, input string name, input int lat);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (sample_out_valid) seen = 1'b1;
        end
        chk(seen, {name, " seen"}, seen, 1);
        if (seen) chk(sample_out == e, name, sample_out, e);
        if (seen && lat > 0) chk(n == lat, {name, " latency"}, n, lat);
    endtask

    task automatic handshake_test();
        logic [7:0] tbl [5];
        int last_acc, low_run, n_acc, kk;
        tbl[0] = 8'h40; tbl[1] = 8'h60; tbl[2] = 8'h60; tbl[3] = 8'h61; tbl[4] = 8'h61;
        last_acc = -1; low_run = 0; n_acc = 0;
        @(posedge clk); #1;
        sample_in = 18'h01000; sample_in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (last_acc >= 0) begin
                kk = i - last_acc - 1 - OP_DLY;
                if (kk >= 0 && kk < 5) chk(opm == tbl[kk], "tap opmode trace", opm, tbl[kk]);
            end
            if (sample_in_ready) begin
                if (low_run > 0) chk(low_run == LAT, "ready low run", low_run, LAT);
                if (last_acc >= 0) chk(i - last_acc == P_LAT + 8, "accept gap", i - last_acc,
                                       P_LAT + 8);
                low_run = 0;
                last_acc = i;
                n_acc++;
            end else begin
                low_run++;
            end
        end
        chk(n_acc == 4, "accept count", n_acc, 4);
        @(posedge clk); #1;
        sample_in_valid = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic reset_mid_mac_test();
        int nv;
        send(18'h08000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk(ain == 18'h0 && bin == 18'h0, "mid-mac reset ain/bin", {ain, bin}, 0);
        chk(sample_in_ready == 1'b1, "mid-mac reset ready", sample_in_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (sample_out_valid) nv++;
        end
        chk(nv == 0, "no output after reset", nv, 0);
        wr_coef(3'd0, 18'h10000);
        wr_coef(3'd3, 18'h38000);
        wr_coef(3'd4, 18'h38000);
        send(18'h08000);
        expect_out(18'h08000, "post-reset passthru", LAT);
        send(18'h00000);
        expect_out(18'h04000, "post-reset feedback", 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Pass-through
        wr_coef(3'd0, 18'h10000);
        send(18'h08000);
        expect_out(18'h08000, "passthru", LAT);

        // Recursive impulse
        do_reset();
        wr_coef(3'd0, 18'h10000);
        wr_coef(3'd3, 18'h38000);
        send(18'h10000); expect_out(18'h10000, "impulse y0", LAT);
        send(18'h00000); expect_out(18'h08000, "impulse y1", LAT);
        send(18'h00000); expect_out(18'h04000, "impulse y2", LAT);

        // Coefficient write during MAC applies to the next sample
        wr_coef(3'd3, 18'h00000);
        send(18'h08000);
        wr_coef(3'd0, 18'h08000);
        expect_out(18'h08000, "coef old b0", 0);
        send(18'h08000);
        expect_out(18'h04000, "coef new b0", LAT);

        // Saturation, positive then negative
        wr_coef(3'd0, 18'h1FFFF);
        wr_coef(3'd1, 18'h1FFFF);
        wr_coef(3'd2, 18'h1FFFF);
        for (int i = 0; i < 3; i++) begin
            send(18'h1FFFF);
            expect_out(18'h1FFFF, "sat pos", LAT);
        end
        wr_coef(3'd0, 18'h20001);
        wr_coef(3'd1, 18'h20001);
        wr_coef(3'd2, 18'h20001);
        for (int i = 0; i < 3; i++) begin
            send(18'h1FFFF);
            expect_out(18'h20000, "sat neg", LAT);
        end

        handshake_test();
        reset_mid_mac_test();

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iir_biquad_seq.md
# iir_biquad_seq

Sequencer for a direct-form-I biquad IIR low-pass stage that drives the DSP48A1 wrapper (`opmode_*`, `ain`, `bin`) and consumes its `pout`. Per input sample it issues five multiply-accumulate taps, then waits out the DSP pipeline. It then saturates and truncates the accumulator into an 18-bit output sample and updates the x/y history. It sits between the audio sample source and the next synth stage, one instance per filter channel.

## Interface

- `OP_DLY`, 1: cycles the block delays its opmode outputs relative to the `ain`/`bin` of the same tap, aligning opmode with the product at the post-adder.
- `P_LAT`, 3: cycles from the last tap's `ain`/`bin` issue until `pout` holds the full sum.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_in`  in  18  signed Q1.17 input sample.
- `sample_in_valid`  in  1  input sample present.
- `sample_in_ready`  out  1  block idle and accepting.
- `sample_out`  out  18  signed Q1.17 filtered sample.
- `sample_out_valid`  out  1  one-cycle pulse when `sample_out` is updated. There is no backpressure.
- `coef_wr`  in  1  coefficient write strobe.
- `coef_addr`  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2. Values 5–7 are ignored.
- `coef_data`  in  18  signed Q2.16 coefficient.
- `opmode_x_in`, `opmode_z_in`  out  2 each  DSP X/Z mux select.
- `opmode_use_preadd`, `opmode_cryin`, `opmode_preadd_sub`, `opmode_postadd_sub`  out  1 each  DSP control bits.
- `ain`, `bin`  out  18 each  multiplier operands: `ain` is the data operand, `bin` is the coefficient.
- `pout`  in  48  DSP accumulator.

## Operation

- **Equation:** y = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- **Coefficients:**
  - `coef_wr` writes a staging register at any time.
  - The staging set is copied to the active set on sample acceptance.
  - A write in the same cycle as acceptance lands in staging and applies to the next sample.
- **States:** IDLE → MAC (5 cycles, tap counter 0..4) → WAIT (P_LAT cycles) → OUT (1 cycle) → IDLE.
- **IDLE:**
  - `sample_in_ready`=1.
  - Opmode outputs are x=00, z=10, so P holds its value.
  - On `sample_in_valid`, the block captures x0 into a register, loads the active coefficients, and moves to MAC.
- **MAC tap k:** drives `ain` = data_k and `bin` = coef_k.
  - Tap 0: x=01, z=00, postadd_sub=0 (P = M).
  - Taps 1–2: x=01, z=10, postadd_sub=0 (P = P + M).
  - Taps 3–4: x=01, z=10, postadd_sub=1 (P = P − M).
- **Fixed control bits:** `opmode_use_preadd`, `opmode_cryin` and `opmode_preadd_sub` are always 0.
- **WAIT:** `ain`/`bin`=0 and opmode is in hold.
- **OUT:**
  - The product format is Q3.33. The result is y = `pout[33:16]`.
  - If `pout[47:33]` is not all equal, y saturates to 0x1FFFF (`pout[47]`=0) or 0x20000 (`pout[47]`=1).
  - y is registered to `sample_out` with `sample_out_valid`=1.
  - In the same cycle: x2←x1, x1←x0, y2←y1, y1←y (the saturated value).
- **Reset:** asynchronous, any state.
  - State returns to IDLE.
  - History and staging/active coefficients clear to 0.
  - Outputs reset to: `sample_in_ready`=1, `sample_out`=0, `sample_out_valid`=0, `ain`=`bin`=0, all opmode bits 0.
  - A sample in flight is discarded and no output is produced.

## Timing

- Acceptance at cycle T0.
- MAC occupies T1..T5.
- Opmode for tap k appears at T(1+k)+OP_DLY.
- WAIT occupies T6..T5+P_LAT.
- OUT is at T6+P_LAT, and `sample_out_valid` is high in cycle T7+P_LAT.
- `sample_in_ready` is 0 from T1 until the return to IDLE. With the defaults, throughput is one sample per 11 cycles (P_LAT+8).
- The opmode delay line is cleared by reset.

## Structure

- Shared package `iir_pkg`:
  - Q-format widths: DATA_W=18, COEF_W=18, ACC_W=48, PROD_FRAC=33.
  - Opmode encodings: X_ZERO=00, X_M=01, Z_ZERO=00, Z_P=10.
  - State enum.
  - Coefficient address constants.
- Sub-module `iir_sat_trunc`: pure combinational 48→18 saturate/truncate, reused by later filter stages.
- The opmode delay line stays inline.

## Test plan

- **Pass-through:** b0=0x10000, others 0; x=0x08000 → `sample_out`=0x08000, valid exactly P_LAT+7 cycles after acceptance.
- **Recursive impulse:** b0=0x10000, a1=0x38000 (−0.5); x = 0x10000, 0, 0 → y = 0x10000, 0x08000, 0x04000.
- **Saturation:**
  - b0=b1=b2=0x1FFFF with x=0x1FFFF repeated → y=0x1FFFF.
  - Negating all three coefficients (b0=b1=b2=0x20001) with the same input → y=0x20000.
- **Coefficient timing:** `coef_wr` of b0=0x08000 during MAC of a sample filtered with b0=0x10000 → the current output uses 0x10000 and the next sample uses 0x08000.
- **Handshake and opmode trace:** `sample_in_valid` held high continuously → ready low for exactly P_LAT+7 cycles, one acceptance per P_LAT+8 cycles. The opmode sequence is checked per tap: 01/00/0, 01/10/0 ×2, 01/10/1 ×2, offset by OP_DLY.
- **Reset mid-MAC:** assert `reset` at tap 2 → no `sample_out_valid`, all outputs at reset values. After reset, the pass-through test is repeated with freshly written coefficients and y1/y2 are confirmed cleared.
